// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, RGB565 colours and raster phase types
// for the VGA scan-side timing controller.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [15:0]        rgb565_t;

  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // Sync bits are carried active-low so the blank state is simply "all high, not valid".
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic valid;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, valid: 1'b0};

  // Eight 80-pixel colour bars: index = x[9:4] / 5.
  function automatic rgb565_t bar_colour(input coord_t x);
    logic [5:0] idx;
    idx = x[9:4] / 6'd5;
    case (idx[2:0])
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Drawer/display-side signal bundle of the VGA timing controller; the
// controller uses the master view, the drawer/board model the slave view.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  rgb565_t iRGB;
  coord_t  oVGA_X;
  coord_t  oVGA_Y;
  logic    oRequest;
  logic    oFrame_start;
  logic    oHsync;
  logic    oVsync;
  logic    oValid;
  rgb565_t oRGB;

  modport master (
    input  iRGB,
    output oVGA_X, oVGA_Y, oRequest, oFrame_start,
    output oHsync, oVsync, oValid, oRGB
  );

  modport slave (
    output iRGB,
    input  oVGA_X, oVGA_Y, oRequest, oFrame_start,
    input  oHsync, oVsync, oValid, oRGB
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Wrap counter 0..TOTAL-1 with active/front/sync/back phase decode; used once
// per raster axis, the vertical instance stepping on the horizontal wrap.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = VGA_H_ACTIVE,
  parameter int FRONT_LEN  = VGA_H_FRONT,
  parameter int SYNC_LEN   = VGA_H_SYNC,
  parameter int BACK_LEN   = VGA_H_BACK
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t cnt,
  output phase_e phase
);

  localparam int     TOTAL     = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam coord_t LAST      = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END   = coord_t'(ACTIVE_LEN);
  localparam coord_t FRONT_END = coord_t'(ACTIVE_LEN + FRONT_LEN);
  localparam coord_t SYNC_END  = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + coord_t'(1);
    end
  end

  // NOTE: phase gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    phase = BACK;
    if (cnt < ACT_END) begin
      phase = ACTIVE;
    end else if (cnt < FRONT_END) begin
      phase = FRONT;
    end else if (cnt < SYNC_END) begin
      phase = SYNC;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: issues pixel coordinates to the drawer and
// re-aligns hsync/vsync/valid with the returned RGB after DRAW_LAT cycles.
// Build option VGA_TEST_PATTERN_EN replaces iRGB with eight colour bars.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DRAW_LAT = 1,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK
) (
  input  logic                  iVGA_CLK,
  input  logic                  iReset_n,
  vga_timing_ctrl_if.master     vga
);

  localparam int     H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam int     LAST_STG = DRAW_LAT + 1;

  coord_t  h_cnt;
  coord_t  v_cnt;
  phase_e  h_phase;
  phase_e  v_phase;
  logic    h_last;
  logic    active;
  rgb565_t rgb_src;

  assign h_last = (h_cnt == H_LAST);
  assign active = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  vga_sync_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK)
  ) u_h_counter (
    .clk   (iVGA_CLK),
    .rst_n (iReset_n),
    .en    (1'b1),
    .cnt   (h_cnt),
    .phase (h_phase)
  );

  vga_sync_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK)
  ) u_v_counter (
    .clk   (iVGA_CLK),
    .rst_n (iReset_n),
    .en    (h_last),
    .cnt   (v_cnt),
    .phase (v_phase)
  );

  // Coordinate stage: the drawer only ever sees in-range coordinates.
  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      vga.oVGA_X       <= '0;
      vga.oVGA_Y       <= '0;
      vga.oRequest     <= 1'b0;
      vga.oFrame_start <= 1'b0;
    end else begin
      vga.oVGA_X       <= active ? h_cnt : '0;
      vga.oVGA_Y       <= active ? v_cnt : '0;
      vga.oRequest     <= active;
      vga.oFrame_start <= active && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // chain[0] sits alongside the coordinate registers; chain[k] is k cycles later,
  // so chain[DRAW_LAT] lines up with the iRGB currently arriving.
  flags_t chain [LAST_STG+1];

  // NOTE: the delay line is short and feeds pins, so every stage is reset to
  // the blank state rather than left unreset like a storage RAM.
  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i <= LAST_STG; i++) begin
        chain[i] <= FLAGS_IDLE;
      end
    end else begin
      chain[0] <= '{hsync_n: (h_phase != SYNC),
                    vsync_n: (v_phase != SYNC),
                    valid:   active};
      for (int i = 1; i <= LAST_STG; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Delayed x, aligned stage-for-stage with chain[], picks the bar colour.
  coord_t x_dly [DRAW_LAT+1];

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i <= DRAW_LAT; i++) begin
        x_dly[i] <= '0;
      end
    end else begin
      x_dly[0] <= active ? h_cnt : '0;
      for (int i = 1; i <= DRAW_LAT; i++) begin
        x_dly[i] <= x_dly[i-1];
      end
    end
  end

  assign rgb_src = bar_colour(x_dly[DRAW_LAT]);
`else
  assign rgb_src = vga.iRGB;
`endif

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      vga.oRGB <= '0;
    end else begin
      vga.oRGB <= chain[DRAW_LAT].valid ? rgb_src : '0;
    end
  end

  assign vga.oHsync = chain[LAST_STG].hsync_n;
  assign vga.oVsync = chain[LAST_STG].vsync_n;
  assign vga.oValid = chain[LAST_STG].valid;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: full-width lines, shortened vertical
// timing so whole frames fit; drawer model returns {y[5:0],x} after 3 cycles.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int LAT    = 3;
  localparam int PIPE   = LAT + 1;
  localparam int H_TOT  = 800;
  localparam int V_ACT  = 4;
  localparam int V_FRT  = 1;
  localparam int V_SYN  = 2;
  localparam int V_BCK  = 2;
  localparam int V_TOT  = V_ACT + V_FRT + V_SYN + V_BCK;
  localparam int FRAME  = H_TOT * V_TOT;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        req;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        valid;
    logic [15:0] rgb;
  } obs_t;

  localparam obs_t RESET_OBS = '{x: 10'd0, y: 10'd0, req: 1'b0, fs: 1'b0,
                                 hs: 1'b1, vs: 1'b1, valid: 1'b0, rgb: 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_timing_ctrl_if vif ();

  vga_timing_ctrl #(
    .DRAW_LAT (LAT),
    .V_ACTIVE (V_ACT),
    .V_FRONT  (V_FRT),
    .V_SYNC   (V_SYN),
    .V_BACK   (V_BCK)
  ) dut (
    .iVGA_CLK (clk),
    .iReset_n (rst_n),
    .vga      (vif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t sample();
    return '{x: vif.oVGA_X, y: vif.oVGA_Y, req: vif.oRequest, fs: vif.oFrame_start,
             hs: vif.oHsync, vs: vif.oVsync, valid: vif.oValid, rgb: vif.oRGB};
  endfunction

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] pixel(input int px, input int py);
    logic [9:0] tx;
    logic [9:0] ty;
    tx = 10'(px);
    ty = 10'(py);
`ifdef VGA_TEST_PATTERN_EN
    return bars[px / 80];
`else
    return {ty[5:0], tx};
`endif
  endfunction

  // Expected outputs seen after the e-th clock edge following reset release.
  function automatic obs_t expect_at(input int e);
    obs_t r;
    int   p, hx, vy, q, qx, qy;
    bit   act, qact;
    p   = e - 1;
    hx  = p % H_TOT;
    vy  = (p / H_TOT) % V_TOT;
    act = (hx < 640) && (vy < V_ACT);
    r.x   = act ? 10'(hx) : 10'd0;
    r.y   = act ? 10'(vy) : 10'd0;
    r.req = act;
    r.fs  = act && (hx == 0) && (vy == 0);
    if (e <= PIPE) begin
      r.hs = 1'b1; r.vs = 1'b1; r.valid = 1'b0; r.rgb = 16'h0000;
    end else begin
      q    = e - 1 - PIPE;
      qx   = q % H_TOT;
      qy   = (q / H_TOT) % V_TOT;
      qact = (qx < 640) && (qy < V_ACT);
      r.hs    = !((qx >= 656) && (qx < 752));
      r.vs    = !((qy >= V_ACT + V_FRT) && (qy < V_ACT + V_FRT + V_SYN));
      r.valid = qact;
      r.rgb   = qact ? pixel(qx, qy) : 16'h0000;
    end
    return r;
  endfunction

  // Drawer model: returns colour for the sampled coordinate LAT cycles later,
  // and garbage for blanking cycles so the output gating is exercised.
  logic [15:0] d0, d1, d2;
  always @(negedge clk) begin
    if (!rst_n) begin
      d0 = '0; d1 = '0; d2 = '0;
      vif.iRGB = '0;
    end else begin
      vif.iRGB = d2;
      d2 = d1;
      d1 = d0;
      d0 = vif.oRequest ? {vif.oVGA_Y[5:0], vif.oVGA_X} : 16'hBEEF;
    end
  end

  // Expectation producer: one entry per clock edge out of reset.
  obs_t exp_q [$];
  int   edge_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt = 0;
    end else begin
      edge_cnt++;
      exp_q.push_back(expect_at(edge_cnt));
    end
  end

  // Monitor: compares the DUT each cycle against the scoreboard.
  always @(negedge clk) begin
    obs_t got;
    got = sample();
    if (!rst_n) begin
      check("reset_hold", 64'(got), 64'(RESET_OBS));
    end else if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 64'(0), 64'(1));
    end else begin
      check("raster", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  task automatic measure_frame(input string tag);
    int   valid_cnt = 0, vs_low = 0, hs_low = 0, hs_fall = 0, fs_cnt = 0;
    int   fs_idx = -1, fall_idx = -1;
    logic prev_hs;
    @(negedge clk);
    prev_hs = vif.oHsync;
    for (int i = 0; i < FRAME; i++) begin
      if (i != 0) @(negedge clk);
      if (vif.oValid) valid_cnt++;
      if (!vif.oVsync) vs_low++;
      if (!vif.oHsync) hs_low++;
      if (vif.oFrame_start) begin
        fs_cnt++;
        fs_idx = i;
      end
      if (prev_hs && !vif.oHsync) begin
        hs_fall++;
        if (fs_idx >= 0 && fall_idx < 0) fall_idx = i;
      end
      prev_hs = vif.oHsync;
    end
    check({tag, "_valid_cycles"}, 64'(valid_cnt), 64'(640 * V_ACT));
    check({tag, "_vsync_low"},    64'(vs_low),    64'(V_SYN * H_TOT));
    check({tag, "_hsync_low"},    64'(hs_low),    64'(96 * V_TOT));
    check({tag, "_hsync_pulses"}, 64'(hs_fall),   64'(V_TOT));
    check({tag, "_frame_starts"}, 64'(fs_cnt),    64'(1));
    check({tag, "_hsync_offset"}, 64'(fall_idx - fs_idx), 64'(656 + PIPE));
  endtask

  initial begin
    #100;
    check("reset_values", 64'(sample()), 64'(RESET_OBS));
    #100;
    @(negedge clk);
    #2 rst_n = 1'b1;
    measure_frame("frame1");

    // Walk to h_cnt=300, v_cnt=2 inside the second frame, then reset there.
    begin
      bit found = 1'b0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
        @(negedge clk);
        if (edge_cnt % FRAME == 2 * H_TOT + 300) found = 1'b1;
      end
      check("reach_mid_frame", 64'(found), 64'(1));
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'(sample()), 64'(RESET_OBS));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    measure_frame("restart");
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
